midi_burst_builder: RTL and testbench

MIDI_BURST_BUILDER -- requirements
Module: midi_burst_builder

---
 rtl/midi_pkg.sv | 41 ++++
 rtl/midi_msg_parser.sv | 74 +++++++
 rtl/midi_burst_builder.sv | 143 ++++++++++++++
 tb/tb_midi_burst_builder.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/midi_pkg.sv
// Shared MIDI constants, parser state enum and message kinds.
// Used by midi_msg_parser and midi_burst_builder.
package midi_pkg;

  localparam int NUM_SLOTS = 5;

  localparam logic [3:0] ST_NOTE_OFF = 4'h8;
  localparam logic [3:0] ST_NOTE_ON  = 4'h9;
  localparam logic [3:0] ST_CTRL     = 4'hB;

  localparam logic [7:0] CC_ALL_NOTES_OFF = 8'h7B;
  localparam logic [7:0] RT_FIRST         = 8'hF8;

  typedef enum logic [1:0] {
    WAIT_STATUS,
    WAIT_DATA1,
    WAIT_DATA2
  } parser_state_t;

  typedef enum logic [1:0] {
    MSG_NONE,
    MSG_NOTE_OFF,
    MSG_NOTE_ON,
    MSG_CTRL
  } msg_type_t;

  function automatic msg_type_t msg_decode(
    input logic [3:0] hi
  );
    msg_type_t t;
    t = MSG_NONE;
    unique case (1'b1)
      hi == ST_NOTE_OFF: t = MSG_NOTE_OFF;
      hi == ST_NOTE_ON:  t = MSG_NOTE_ON;
      hi == ST_CTRL:     t = MSG_CTRL;
      default:           t = MSG_NONE;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/midi_msg_parser.sv
// Byte classifier with running status; msg_valid is combinational
// on the completing data byte. Ports: clk_in, rst_n_in, byte_in,
// byte_valid_in -> msg_valid, msg_type, data1, data2.
module midi_msg_parser
  import midi_pkg::*;
#(
  parameter logic [3:0] CHANNEL = 4'd0
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic [7:0] byte_in,
  input  logic       byte_valid_in,
  output logic       msg_valid,
  output msg_type_t  msg_type,
  output logic [6:0] data1,
  output logic [6:0] data2
);

  parser_state_t state_q, state_d;
  msg_type_t     run_q, run_d;
  logic [6:0]    d1_q, d1_d;
  msg_type_t     dec;
  logic          take;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= WAIT_STATUS;
      run_q   <= MSG_NONE;
      d1_q    <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      d1_q    <= d1_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    run_d     = run_q;
    d1_d      = d1_q;
    msg_valid = 1'b0;
    dec       = msg_decode(byte_in[7:4]);
    // Real-time bytes pass through without touching state.
    take      = byte_valid_in && (byte_in < RT_FIRST);
    if (take) begin
      if (byte_in[7]) begin
        if (byte_in[3:0] == CHANNEL && dec != MSG_NONE) begin
          run_d   = dec;
          state_d = WAIT_DATA1;
        end else begin
          run_d   = MSG_NONE;
          state_d = WAIT_STATUS;
        end
      end else begin
        unique case (state_q)
          WAIT_DATA1: begin
            d1_d    = byte_in[6:0];
            state_d = WAIT_DATA2;
          end
          WAIT_DATA2: begin
            msg_valid = 1'b1;
            state_d   = WAIT_DATA1;
          end
          default: ;
        endcase
      end
    end
  end

  assign msg_type = run_q;
  assign data1    = d1_q;
  assign data2    = byte_in[6:0];

endmodule

// File: rtl/midi_burst_builder.sv
// Note slot table driven by parsed MIDI messages; slot 0 reserved.
// Optional macro VOICE_STEAL_EN: steal the oldest slot when full.
module midi_burst_builder #(
  parameter logic [3:0] CHANNEL   = 4'd0,
  parameter int         NUM_SLOTS = midi_pkg::NUM_SLOTS
) (
  input  logic                          clk_in,
  input  logic                          rst_n_in,
  input  logic [7:0]                    midi_byte_in,
  input  logic                          midi_byte_valid_in,
  output logic [NUM_SLOTS-1:0][15:0]    midi_burst_data_out,
  output logic [NUM_SLOTS-1:0]          on_array_out,
  output logic                          midi_burst_change_out,
  output logic [2:0]                    active_count_out
);

  import midi_pkg::*;

  localparam int IW = $clog2(NUM_SLOTS);

  logic       msg_valid;
  msg_type_t  msg_type;
  logic [6:0] d1, d2;

  logic [NUM_SLOTS-1:0][15:0] tab_d;
  logic [NUM_SLOTS-1:0]       on_d;
  logic [NUM_SLOTS-1:0][1:0]  age_q, age_d;
  logic [2:0]                 cnt_d;
  logic                       chg;

  logic          is_on, is_off, is_clr;
  logic          hit, free_ok, alloc_ok;
  logic [IW-1:0] hit_idx, free_idx, alloc_idx;
`ifdef VOICE_STEAL_EN
  logic [IW-1:0] vic_idx;
  logic [1:0]    vic_age;
`endif

  midi_msg_parser #(
    .CHANNEL(CHANNEL)
  ) u_parser (
    .clk_in       (clk_in),
    .rst_n_in     (rst_n_in),
    .byte_in      (midi_byte_in),
    .byte_valid_in(midi_byte_valid_in),
    .msg_valid    (msg_valid),
    .msg_type     (msg_type),
    .data1        (d1),
    .data2        (d2)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      midi_burst_data_out   <= '0;
      on_array_out          <= '0;
      age_q                 <= '0;
      active_count_out      <= '0;
      midi_burst_change_out <= 1'b0;
    end else begin
      midi_burst_data_out   <= tab_d;
      on_array_out          <= on_d;
      age_q                 <= age_d;
      active_count_out      <= cnt_d;
      midi_burst_change_out <= chg;
    end
  end

  always_comb begin
    tab_d     = midi_burst_data_out;
    on_d      = on_array_out;
    age_d     = age_q;
    hit       = 1'b0;
    hit_idx   = '0;
    free_ok   = 1'b0;
    free_idx  = '0;
    is_on  = msg_valid && msg_type == MSG_NOTE_ON
          && d2 != 7'd0;
    is_off = msg_valid && (msg_type == MSG_NOTE_OFF
          || (msg_type == MSG_NOTE_ON && d2 == 7'd0));
    is_clr = msg_valid && msg_type == MSG_CTRL
          && {1'b0, d1} == CC_ALL_NOTES_OFF;
    // Descending scan so the lowest matching index wins.
    for (int i = NUM_SLOTS - 1; i >= 1; i--) begin
      if (on_array_out[i]
          && midi_burst_data_out[i][15:8] == {1'b0, d1}) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
      if (!on_array_out[i]) begin
        free_ok  = 1'b1;
        free_idx = IW'(i);
      end
    end
    alloc_ok  = free_ok;
    alloc_idx = free_idx;
`ifdef VOICE_STEAL_EN
    // Strict compare keeps the lowest index on equal ages.
    vic_idx = IW'(1);
    vic_age = age_q[1];
    for (int i = 2; i < NUM_SLOTS; i++) begin
      if (age_q[i] > vic_age) begin
        vic_idx = IW'(i);
        vic_age = age_q[i];
      end
    end
    if (!free_ok) begin
      alloc_ok  = 1'b1;
      alloc_idx = vic_idx;
    end
`endif
    unique case (1'b1)
      is_on && hit: begin
        tab_d[hit_idx][7:0] = {1'b0, d2};
      end
      is_on && !hit && alloc_ok: begin
        for (int i = 1; i < NUM_SLOTS; i++) begin
          if (on_array_out[i] && age_q[i] != 2'd3)
            age_d[i] = age_q[i] + 2'd1;
        end
        tab_d[alloc_idx] = {1'b0, d1, 1'b0, d2};
        on_d[alloc_idx]  = 1'b1;
        age_d[alloc_idx] = 2'd0;
      end
      is_off && hit: begin
        tab_d[hit_idx] = '0;
        on_d[hit_idx]  = 1'b0;
        age_d[hit_idx] = 2'd0;
      end
      is_clr: begin
        tab_d = '0;
        on_d  = '0;
        age_d = '0;
      end
      default: ;
    endcase
    cnt_d = '0;
    for (int i = 1; i < NUM_SLOTS; i++)
      cnt_d = cnt_d + {2'b0, on_d[i]};
    chg = (tab_d != midi_burst_data_out)
       || (on_d != on_array_out);
  end

endmodule

// File: tb/tb_midi_burst_builder.sv
// Directed bench for midi_burst_builder with an expectation queue.
// Build with or without VOICE_STEAL_EN to match the DUT.
module tb_midi_burst_builder;

  typedef struct packed {
    logic [4:0][15:0] d;
    logic [4:0]       on;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic [7:0]       mb;
  logic             mv;
  logic [4:0][15:0] data;
  logic [4:0]       on;
  logic             chg;
  logic [2:0]       cnt;

  int   checks;
  int   failures;
  exp_t wt, ht, e;
  exp_t sb[$];

  midi_burst_builder dut (
    .clk_in               (clk),
    .rst_n_in             (rst_n),
    .midi_byte_in         (mb),
    .midi_byte_valid_in   (mv),
    .midi_burst_data_out  (data),
    .on_array_out         (on),
    .midi_burst_change_out(chg),
    .active_count_out     (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic send(input logic [7:0] b);
    mb = b;
    mv = 1'b1;
    @(negedge clk);
    mv = 1'b0;
    #1;
    checks++;
    assert (sb.size() == 0) else begin
      failures++;
      $error("FAIL strobe_due byte=%h pending=%0d want=0",
             b, sb.size());
      sb.delete();
    end
  endtask

  task automatic set_slot(input int i, input logic [15:0] v);
    wt.d[i]  = v;
    wt.on[i] = 1'b1;
  endtask

  task automatic clr_slot(input int i);
    wt.d[i]  = '0;
    wt.on[i] = 1'b0;
  endtask

  task automatic push();
    sb.push_back(wt);
  endtask

  task automatic chk_zero(input string tag);
    checks++;
    assert (data === '0) else begin
      failures++;
      $error("FAIL %s_data got=%h want=0", tag, data);
    end
    checks++;
    assert (on === 5'b0) else begin
      failures++;
      $error("FAIL %s_on got=%b want=0", tag, on);
    end
    checks++;
    assert (cnt === 3'd0) else begin
      failures++;
      $error("FAIL %s_cnt got=%0d want=0", tag, cnt);
    end
    checks++;
    assert (chg === 1'b0) else begin
      failures++;
      $error("FAIL %s_chg got=%b want=0", tag, chg);
    end
  endtask

  task automatic do_reset(input string tag);
    mv = 1'b0;
    rst_n = 1'b0;
    #2;
    chk_zero(tag);
    wt = '0;
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    wt = '0;
    ht = '0;
    mb = 8'h00;
    mv = 1'b0;
    rst_n = 1'b1;
    #1;
    rst_n = 1'b0;
    #2;
    chk_zero("por");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    fork
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          ht = '0;
        end else if (chg) begin
          checks++;
          assert (sb.size() != 0) else begin
            failures++;
            $error("FAIL spurious_strobe got=1 want=0");
          end
          if (sb.size() != 0) begin
            e = sb.pop_front();
            ht = e;
            checks++;
            assert (data === e.d) else begin
              failures++;
              $error("FAIL slot_data got=%h want=%h",
                     data, e.d);
            end
            checks++;
            assert (on === e.on) else begin
              failures++;
              $error("FAIL on_array got=%b want=%b",
                     on, e.on);
            end
            checks++;
            assert (cnt === 3'($countones(e.on))) else begin
              failures++;
              $error("FAIL active_cnt got=%0d want=%0d",
                     cnt, $countones(e.on));
            end
          end
        end else begin
          checks++;
          assert ({data, on, cnt} ===
                  {ht.d, ht.on, 3'($countones(ht.on))})
          else begin
            failures++;
            $error("FAIL hold got=%h/%b want=%h/%b",
                   data, on, ht.d, ht.on);
          end
        end
      end
    join_none

    // Basic note on, then running status second note.
    send(8'h90);
    send(8'h3C);
    set_slot(1, 16'h3C64);
    push();
    send(8'h64);
    send(8'h40);
    set_slot(2, 16'h4050);
    push();
    send(8'h50);
    send(8'h80);
    send(8'h3C);
    clr_slot(1);
    push();
    send(8'h00);

    do_reset("rst1");

    // Real-time byte inside a message is transparent.
    send(8'h90);
    send(8'h3C);
    send(8'hF8);
    set_slot(1, 16'h3C64);
    push();
    send(8'h64);

    // Foreign channel and sysex clear running status.
    send(8'h91);
    send(8'h3C);
    send(8'h64);
    send(8'h45);
    send(8'h46);
    send(8'hF0);
    send(8'h01);
    send(8'h02);

    // Note On velocity 0 releases; unheld Note Off is silent.
    send(8'h90);
    send(8'h3C);
    clr_slot(1);
    push();
    send(8'h00);
    send(8'h80);
    send(8'h11);
    send(8'h00);

    // Fill all four slots, then a fifth note.
    send(8'h90);
    send(8'h30);
    set_slot(1, 16'h3010);
    push();
    send(8'h10);
    send(8'h31);
    set_slot(2, 16'h3111);
    push();
    send(8'h11);
    send(8'h32);
    set_slot(3, 16'h3212);
    push();
    send(8'h12);
    send(8'h33);
    set_slot(4, 16'h3313);
    push();
    send(8'h13);
    send(8'h34);
`ifdef VOICE_STEAL_EN
    set_slot(1, 16'h3414);
    push();
`endif
    send(8'h14);

    // Velocity update of a held note.
    send(8'h32);
    set_slot(3, 16'h327F);
    push();
    send(8'h7F);

    // Status mid-message abandons the partial note on.
    send(8'h90);
    send(8'h35);
    send(8'h80);
    send(8'h33);
    clr_slot(4);
    push();
    send(8'h00);

    // Other CC ignored, CC 123 clears three held notes.
    send(8'hB0);
    send(8'h07);
    send(8'h40);
    send(8'hB0);
    send(8'h7B);
    wt = '0;
    push();
    send(8'h00);

    // Lowest free slot reused after a hole opens.
    send(8'h90);
    send(8'h50);
    set_slot(1, 16'h5060);
    push();
    send(8'h60);
    send(8'h51);
    set_slot(2, 16'h5161);
    push();
    send(8'h61);
    send(8'h80);
    send(8'h50);
    clr_slot(1);
    push();
    send(8'h00);
    send(8'h90);
    send(8'h52);
    set_slot(1, 16'h5262);
    push();
    send(8'h62);

    // Reset mid-message discards the partial message.
    send(8'h90);
    send(8'h3C);
    do_reset("rst2");
    send(8'h64);

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
